noc_linreg_master: RTL and testbench



---
 rtl/noc_linreg_master_if.sv | 38 +++
 rtl/noc_linreg_master.sv | 127 ++++++++++++
 tb/tb_noc_linreg_master.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_linreg_master_if.sv
// noc_linreg_master_if: request, network and response signals of the NoC linear-register master
//   request : req_valid/req_data/req_tail in, req_ready back
//   inject  : flit_to_send/send_flit_flag out, credit_to_accept in
//   eject   : flit_to_receive in, credit_to_send/send_credit_flag out
//   response: rsp_valid/rsp_data/rsp_tail out, rsp_ready in
//   master modport is the NoC master itself, slave modport is its environment
interface noc_linreg_master_if #(
    parameter int FLIT_DATA_WIDTH = 64,
    parameter int DEST_BITS       = 1,
    parameter int VC_BITS         = 1
);
    localparam int FW = 2 + FLIT_DATA_WIDTH + DEST_BITS + VC_BITS;
    localparam int CW = 1 + VC_BITS;
    logic                       req_valid;
    logic [FLIT_DATA_WIDTH-1:0] req_data;
    logic                       req_tail;
    logic                       req_ready;
    logic [FW-1:0]              flit_to_send;
    logic                       send_flit_flag;
    logic [CW-1:0]              credit_to_accept;
    logic [FW-1:0]              flit_to_receive;
    logic [CW-1:0]              credit_to_send;
    logic                       send_credit_flag;
    logic                       rsp_valid;
    logic [FLIT_DATA_WIDTH-1:0] rsp_data;
    logic                       rsp_tail;
    logic                       rsp_ready;
    modport master (
        input  req_valid, req_data, req_tail, credit_to_accept, flit_to_receive, rsp_ready,
        output req_ready, flit_to_send, send_flit_flag, credit_to_send, send_credit_flag,
               rsp_valid, rsp_data, rsp_tail
    );
    modport slave (
        output req_valid, req_data, req_tail, credit_to_accept, flit_to_receive, rsp_ready,
        input  req_ready, flit_to_send, send_flit_flag, credit_to_send, send_credit_flag,
               rsp_valid, rsp_data, rsp_tail
    );
endinterface

// File: rtl/noc_linreg_master.sv
// noc_linreg_master: credit-based NoC injection master with a 4-deep request FIFO and 2-deep response buffer
//   CLK, RST      : single clock, synchronous active-high reset
//   bus (master)  : request, flit injection/credit, ejection/credit-return and response signals
//   outstanding   : packets injected whose tail response has not been consumed
//   cred_err      : sticky flag for credit overflow or a flit arriving at a full receive buffer
//   flits_sent, stall_cycles : saturating statistics, live only when NOC_MASTER_STATS_EN is defined
//   flits are {valid,tail,dest,vc,data}; credits are {valid,vc}
module noc_linreg_master #(
    parameter int FLIT_DATA_WIDTH = 64,
    parameter int DEST_BITS       = 1,
    parameter int VC_BITS         = 1,
    parameter int NUM_CREDITS     = 4,
    parameter int DEST_PORT       = 0
) (
    input  logic                CLK,
    input  logic                RST,
    noc_linreg_master_if.master bus,
    output logic [2:0]          outstanding,
    output logic                cred_err,
    output logic [15:0]         flits_sent,
    output logic [15:0]         stall_cycles
);
    localparam int DW = FLIT_DATA_WIDTH;
    localparam int FW = 2 + DW + DEST_BITS + VC_BITS;
    localparam int CW = 1 + VC_BITS;
    localparam int RW = DW + VC_BITS + 1;
    localparam logic [3:0] CRED_MAX = 4'(NUM_CREDITS);
    typedef enum logic {TX_HEAD, TX_BODY} state_t;
    state_t state;
    logic [DW:0]        req_mem [4];
    logic [1:0]         req_wp, req_rp;
    logic [2:0]         req_cnt;
    logic [DW:0]        req_head;
    logic [3:0]         credit_cnt;
    logic               req_rdy, req_push, inject, cred_in, head_tail, tail_inj;
    logic [RW-1:0]      rx_mem [2];
    logic               rx_wp, rx_rp;
    logic [1:0]         rx_cnt;
    logic [RW-1:0]      rx_head;
    logic               rx_in, rx_push, rx_pop, rsp_v, tail_pop;
    logic               cr_flag;
    logic [VC_BITS-1:0] cr_vc;
    logic               unused_bits;
    assign unused_bits = ^{bus.flit_to_receive[FW-3 -: DEST_BITS], bus.credit_to_accept[CW-2:0]};
    assign req_head  = req_mem[req_rp];
    assign head_tail = req_head[DW];
    assign req_rdy   = !RST && req_cnt != 3'd4 && outstanding != 3'd7;
    assign req_push  = bus.req_valid && req_rdy;
    assign inject    = !RST && req_cnt != '0 && credit_cnt != '0;
    assign tail_inj  = inject && head_tail;
    assign cred_in   = bus.credit_to_accept[CW-1];
    assign bus.req_ready      = req_rdy;
    assign bus.send_flit_flag = inject;
    assign bus.flit_to_send   = inject ? {1'b1, head_tail, DEST_BITS'(DEST_PORT), {VC_BITS{1'b0}}, req_head[DW-1:0]} : '0;
    // receive entries keep {tail,vc,data}; vc is needed for the credit returned on consumption
    assign rx_head  = rx_mem[rx_rp];
    assign rx_in    = bus.flit_to_receive[FW-1];
    assign rx_push  = rx_in && rx_cnt != 2'd2;
    assign rsp_v    = !RST && rx_cnt != '0;
    assign rx_pop   = rsp_v && bus.rsp_ready;
    assign tail_pop = rx_pop && rx_head[RW-1];
    assign bus.rsp_valid        = rsp_v;
    assign bus.rsp_data         = rsp_v ? rx_head[DW-1:0] : '0;
    assign bus.rsp_tail         = rsp_v && rx_head[RW-1];
    assign bus.send_credit_flag = !RST && cr_flag;
    assign bus.credit_to_send   = (!RST && cr_flag) ? {1'b1, cr_vc} : '0;
    always_ff @(posedge CLK) begin
        if (req_push) req_mem[req_wp] <= {bus.req_tail, bus.req_data};
        if (rx_push) rx_mem[rx_wp] <= {bus.flit_to_receive[FW-2], bus.flit_to_receive[DW+VC_BITS-1:0]};
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_wp      <= '0;
            req_rp      <= '0;
            req_cnt     <= '0;
            rx_wp       <= 1'b0;
            rx_rp       <= 1'b0;
            rx_cnt      <= '0;
            credit_cnt  <= CRED_MAX;
            state       <= TX_HEAD;
            outstanding <= '0;
            cred_err    <= 1'b0;
            cr_flag     <= 1'b0;
            cr_vc       <= '0;
        end else begin
            req_wp  <= req_wp + 2'(req_push);
            req_rp  <= req_rp + 2'(inject);
            req_cnt <= req_cnt + 3'(req_push) - 3'(inject);
            // coincident credit and injection cancel; a credit beyond the initial pool is an error
            if (inject && !cred_in)
                credit_cnt <= credit_cnt - 4'd1;
            else if (cred_in && !inject && credit_cnt != CRED_MAX)
                credit_cnt <= credit_cnt + 4'd1;
            if (inject)
                state <= head_tail ? TX_HEAD : TX_BODY;
            if (tail_inj && !tail_pop && outstanding != 3'd7)
                outstanding <= outstanding + 3'd1;
            else if (tail_pop && !tail_inj && outstanding != '0)
                outstanding <= outstanding - 3'd1;
            // a flit arriving at a full buffer is dropped even if the head is popped this cycle
            rx_wp  <= rx_wp ^ rx_push;
            rx_rp  <= rx_rp ^ rx_pop;
            rx_cnt <= rx_cnt + 2'(rx_push) - 2'(rx_pop);
            if ((cred_in && !inject && credit_cnt == CRED_MAX) || (rx_in && rx_cnt == 2'd2))
                cred_err <= 1'b1;
            cr_flag <= rx_pop;
            cr_vc   <= rx_pop ? rx_head[DW+VC_BITS-1:DW] : '0;
        end
    end
`ifdef NOC_MASTER_STATS_EN
    logic [15:0] flits_q, stall_q;
    always_ff @(posedge CLK) begin
        if (RST) begin
            flits_q <= '0;
            stall_q <= '0;
        end else begin
            if (inject && flits_q != 16'hFFFF) flits_q <= flits_q + 16'd1;
            if (req_cnt != '0 && credit_cnt == '0 && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end
    assign flits_sent   = RST ? '0 : flits_q;
    assign stall_cycles = RST ? '0 : stall_q;
`else
    assign flits_sent   = '0;
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_noc_linreg_master.sv
// tb_noc_linreg_master: table-driven and directed checks of noc_linreg_master
module tb_noc_linreg_master;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
`ifdef NOC_MASTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    noc_linreg_master_if #(.FLIT_DATA_WIDTH(64), .DEST_BITS(1), .VC_BITS(1)) bus();
    logic [2:0]  outstanding;
    logic        cred_err;
    logic [15:0] flits_sent, stall_cycles;
    noc_linreg_master #(
        .FLIT_DATA_WIDTH(64), .DEST_BITS(1), .VC_BITS(1), .NUM_CREDITS(4), .DEST_PORT(0)
    ) dut (
        .CLK(clk), .RST(rst), .bus(bus),
        .outstanding(outstanding), .cred_err(cred_err),
        .flits_sent(flits_sent), .stall_cycles(stall_cycles)
    );
    typedef struct {
        logic        rv;
        logic [63:0] rd;
        logic        rt;
        logic        cv;
        logic        rxv;
        logic        rxt;
        logic [63:0] rxd;
        logic        rr;
        logic        rdy;
        logic        snd;
        logic [67:0] flit;
        logic [3:0]  cnt;
        logic [2:0]  outs;
        logic        err;
        logic        rspv;
        logic [63:0] rspd;
        logic        cf;
        logic [1:0]  cts;
    } vec_t;
    vec_t tbl[13];
    int pass_cnt = 0;
    int total = 0;
    int pushed, sent;
    logic bad;
    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_data = '0;
        bus.req_tail = 1'b0;
        bus.credit_to_accept = '0;
        bus.flit_to_receive = '0;
        bus.rsp_ready = 1'b0;
    endtask
    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask
    initial begin
        tbl[0]  = '{1'b1, 64'h8, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 68'h0, 4'd4, 3'd0, 1'b0, 1'b0, 64'h0, 1'b0, 2'b00};
        tbl[1]  = '{1'b1, 64'h1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 68'h8_0000_0000_0000_0008, 4'd4, 3'd0, 1'b0, 1'b0, 64'h0, 1'b0, 2'b00};
        tbl[2]  = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 68'hC_0000_0000_0000_0001, 4'd3, 3'd0, 1'b0, 1'b0, 64'h0, 1'b0, 2'b00};
        tbl[3]  = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 68'h0, 4'd2, 3'd1, 1'b0, 1'b0, 64'h0, 1'b0, 2'b00};
        tbl[4]  = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h2A, 1'b0, 1'b1, 1'b0, 68'h0, 4'd2, 3'd1, 1'b0, 1'b0, 64'h0, 1'b0, 2'b00};
        tbl[5]  = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 68'h0, 4'd2, 3'd1, 1'b0, 1'b1, 64'h2A, 1'b0, 2'b00};
        tbl[6]  = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 68'h0, 4'd2, 3'd1, 1'b0, 1'b1, 64'h2A, 1'b0, 2'b00};
        tbl[7]  = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 68'h0, 4'd2, 3'd1, 1'b0, 1'b1, 64'h2A, 1'b0, 2'b00};
        tbl[8]  = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 68'h0, 4'd2, 3'd1, 1'b0, 1'b1, 64'h2A, 1'b0, 2'b00};
        tbl[9]  = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 68'h0, 4'd2, 3'd0, 1'b0, 1'b0, 64'h0, 1'b1, 2'b10};
        tbl[10] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 68'h0, 4'd2, 3'd0, 1'b0, 1'b0, 64'h0, 1'b0, 2'b00};
        tbl[11] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 68'h0, 4'd3, 3'd0, 1'b0, 1'b0, 64'h0, 1'b0, 2'b00};
        tbl[12] = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 68'h0, 4'd4, 3'd0, 1'b0, 1'b0, 64'h0, 1'b0, 2'b00};
        rst = 1'b1;
        idle();
        @(negedge clk);
        tick();
        #1;
        chk("rst_req_ready", 68'(bus.req_ready), 68'(0));
        chk("rst_send_flag", 68'(bus.send_flit_flag), 68'(0));
        chk("rst_flit", bus.flit_to_send, 68'(0));
        chk("rst_credit_flag", 68'(bus.send_credit_flag), 68'(0));
        chk("rst_credit", 68'(bus.credit_to_send), 68'(0));
        chk("rst_rsp_valid", 68'(bus.rsp_valid), 68'(0));
        chk("rst_outstanding", 68'(outstanding), 68'(0));
        chk("rst_cred_err", 68'(cred_err), 68'(0));
        chk("rst_flits_sent", 68'(flits_sent), 68'(0));
        chk("rst_stall", 68'(stall_cycles), 68'(0));
        chk("rst_credit_cnt", 68'(dut.credit_cnt), 68'(4));
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            bus.req_valid = tbl[i].rv;
            bus.req_data = tbl[i].rd;
            bus.req_tail = tbl[i].rt;
            bus.credit_to_accept = {tbl[i].cv, 1'b0};
            bus.flit_to_receive = {tbl[i].rxv, tbl[i].rxt, 1'b0, 1'b0, tbl[i].rxd};
            bus.rsp_ready = tbl[i].rr;
            #1;
            chk($sformatf("r%0d_req_ready", i), 68'(bus.req_ready), 68'(tbl[i].rdy));
            chk($sformatf("r%0d_send_flag", i), 68'(bus.send_flit_flag), 68'(tbl[i].snd));
            chk($sformatf("r%0d_flit", i), bus.flit_to_send, tbl[i].flit);
            chk($sformatf("r%0d_credit_cnt", i), 68'(dut.credit_cnt), 68'(tbl[i].cnt));
            chk($sformatf("r%0d_outstanding", i), 68'(outstanding), 68'(tbl[i].outs));
            chk($sformatf("r%0d_cred_err", i), 68'(cred_err), 68'(tbl[i].err));
            chk($sformatf("r%0d_rsp_valid", i), 68'(bus.rsp_valid), 68'(tbl[i].rspv));
            chk($sformatf("r%0d_rsp_data", i), 68'(bus.rsp_data), 68'(tbl[i].rspd));
            chk($sformatf("r%0d_credit_flag", i), 68'(bus.send_credit_flag), 68'(tbl[i].cf));
            chk($sformatf("r%0d_credit_out", i), 68'(bus.credit_to_send), 68'(tbl[i].cts));
            tick();
        end
        // credit exhaustion: six pushes, four injections, then stalls until credits return
        do_reset();
        pushed = 0;
        sent = 0;
        for (int i = 0; i < 12; i++) begin
            bus.req_valid = pushed < 6;
            bus.req_data = 64'(100 + pushed);
            #1;
            if (bus.send_flit_flag) begin
                chk("stall_flit", bus.flit_to_send, {4'h8, 64'(100 + sent)});
                sent++;
            end
            if (bus.req_valid && bus.req_ready) pushed++;
            tick();
        end
        idle();
        #1;
        chk("stall_sent", 68'(sent), 68'(4));
        chk("stall_pushed", 68'(pushed), 68'(6));
        chk("stall_credit_cnt", 68'(dut.credit_cnt), 68'(0));
        chk("stall_cycles7", 68'(stall_cycles), 68'(STATS ? 16'd7 : 16'd0));
        chk("stall_flits4", 68'(flits_sent), 68'(STATS ? 16'd4 : 16'd0));
        bus.credit_to_accept = 2'b10;
        chk("stall_no_send", 68'(bus.send_flit_flag), 68'(0));
        tick();
        bus.credit_to_accept = 2'b00;
        #1;
        chk("fifth_send", 68'(bus.send_flit_flag), 68'(1));
        chk("fifth_flit", bus.flit_to_send, {4'h8, 64'd104});
        chk("stall_cycles8", 68'(stall_cycles), 68'(STATS ? 16'd8 : 16'd0));
        tick();
        #1;
        chk("sixth_wait", 68'(bus.send_flit_flag), 68'(0));
        bus.credit_to_accept = 2'b10;
        tick();
        #1;
        chk("sixth_send", 68'(bus.send_flit_flag), 68'(1));
        chk("sixth_flit", bus.flit_to_send, {4'h8, 64'd105});
        tick();
        bus.credit_to_accept = 2'b00;
        #1;
        chk("coincide_cnt", 68'(dut.credit_cnt), 68'(1));
        chk("coincide_idle", 68'(bus.send_flit_flag), 68'(0));
        chk("stall_cycles9", 68'(stall_cycles), 68'(STATS ? 16'd9 : 16'd0));
        chk("flits6", 68'(flits_sent), 68'(STATS ? 16'd6 : 16'd0));
        // surplus credits after reset
        do_reset();
        bus.credit_to_accept = 2'b10;
        for (int i = 0; i < 5; i++) tick();
        idle();
        #1;
        chk("ovf_cred_err", 68'(cred_err), 68'(1));
        chk("ovf_credit_cnt", 68'(dut.credit_cnt), 68'(4));
        // three back-to-back response flits into a 2-entry buffer
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            bus.flit_to_receive = {4'h8, 64'(i)};
            tick();
        end
        idle();
        #1;
        chk("rxfull_cred_err", 68'(cred_err), 68'(1));
        chk("rxfull_valid", 68'(bus.rsp_valid), 68'(1));
        chk("rxfull_data1", 68'(bus.rsp_data), 68'(1));
        bus.rsp_ready = 1'b1;
        tick();
        #1;
        chk("rxfull_data2", 68'(bus.rsp_data), 68'(2));
        chk("rxfull_credit1", 68'(bus.credit_to_send), 68'(2'b10));
        tick();
        #1;
        chk("rxfull_empty", 68'(bus.rsp_valid), 68'(0));
        chk("rxfull_credit2", 68'(bus.send_credit_flag), 68'(1));
        bus.rsp_ready = 1'b0;
        tick();
        #1;
        chk("rxfull_credit_end", 68'(bus.send_credit_flag), 68'(0));
        chk("rxfull_outstanding", 68'(outstanding), 68'(0));
        // reset in the middle of a packet
        do_reset();
        bus.req_valid = 1'b1;
        bus.req_data = 64'h55;
        tick();
        bus.req_valid = 1'b0;
        #1;
        chk("mid_head_flit", bus.flit_to_send, 68'h8_0000_0000_0000_0055);
        tick();
        #1;
        chk("mid_state_body", 68'(dut.state), 68'(1));
        chk("mid_cnt3", 68'(dut.credit_cnt), 68'(3));
        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_data = 64'h66;
        bus.req_tail = 1'b1;
        #1;
        chk("mid_rst_ready", 68'(bus.req_ready), 68'(0));
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("mid_state_head", 68'(dut.state), 68'(0));
        chk("mid_cnt4", 68'(dut.credit_cnt), 68'(4));
        chk("mid_ready", 68'(bus.req_ready), 68'(1));
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.send_flit_flag) bad = 1'b1;
            tick();
        end
        chk("mid_no_flits", 68'(bad), 68'(0));
        bus.req_valid = 1'b1;
        bus.req_data = 64'h77;
        bus.req_tail = 1'b1;
        tick();
        idle();
        #1;
        chk("mid_next_flit", bus.flit_to_send, 68'hC_0000_0000_0000_0077);
        tick();
        #1;
        chk("mid_outstanding", 68'(outstanding), 68'(1));
        chk("mid_state_end", 68'(dut.state), 68'(0));
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
